// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/MEM request-response handshakes and the byte-wide RAM port.
interface mem_arbiter_if #(parameter int ADDR_WIDTH = 32);
   logic                  inst_req;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_flush;
   logic [31:0]           inst_o;
   logic [ADDR_WIDTH-1:0] inst_pc;
   logic                  inst_done;
   logic                  data_req;
   logic                  data_we;
   logic [1:0]            data_len;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [31:0]           data_i;
   logic [31:0]           data_o;
   logic                  data_done;
   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;
   logic                  busy;
   modport slave (
      input  inst_req, inst_addr, inst_flush, data_req, data_we, data_len, data_addr, data_i, mem_din,
      output inst_o, inst_pc, inst_done, data_o, data_done, mem_dout, mem_a, mem_wr, busy
   );
   modport master (
      output inst_req, inst_addr, inst_flush, data_req, data_we, data_len, data_addr, data_i, mem_din,
      input  inst_o, inst_pc, inst_done, data_o, data_done, mem_dout, mem_a, mem_wr, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between IF refills and MEM loads/stores,
// streaming 1/2/4-byte accesses little-endian with alternating-priority arbitration.
module mem_arbiter #(parameter int ADDR_WIDTH = 32) (
   input logic         clk,
   input logic         rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, IF_RD, DATA_RD, DATA_WR} state_t;
   state_t                r_state;
   logic [2:0]            r_cnt;
   logic [2:0]            r_len;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_word;
   logic                  r_last_data;
   logic                  w_if_ok;
   logic                  w_accept;
   logic                  w_grant_data;
   logic                  w_grant_if;
   logic                  w_last;
   logic [2:0]            w_next;
   logic [2:0]            w_dlen;
   logic [31:0]           w_word;
   // The done-pulse terms enforce the one-cycle gap between back-to-back transactions.
   assign w_if_ok      = bus.inst_req & ~bus.inst_flush;
   assign w_accept     = (r_state == IDLE) & ~bus.inst_done & ~bus.data_done;
   assign w_grant_data = w_accept & bus.data_req & (~w_if_ok | ~r_last_data);
   assign w_grant_if   = w_accept & w_if_ok & (~bus.data_req | r_last_data);
   assign w_dlen       = bus.data_len[1] ? 3'd4 : bus.data_len[0] ? 3'd2 : 3'd1;
   assign w_next       = r_cnt + 3'd1;
   assign w_last       = w_next == r_len;
   assign w_word       = r_word | (32'(bus.mem_din) << {r_cnt[1:0], 3'b000});
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_len         <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_word        <= '0;
         r_last_data   <= 1'b0;
         bus.inst_o    <= '0;
         bus.inst_pc   <= '0;
         bus.inst_done <= 1'b0;
         bus.data_o    <= '0;
         bus.data_done <= 1'b0;
         bus.mem_a     <= '0;
         bus.mem_dout  <= '0;
         bus.mem_wr    <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.inst_done <= 1'b0;
         bus.data_done <= 1'b0;
         case (r_state)
            IDLE: if (w_grant_data || w_grant_if) begin
               r_state     <= w_grant_if ? IF_RD : bus.data_we ? DATA_WR : DATA_RD;
               r_last_data <= w_grant_data;
               r_len       <= w_grant_if ? 3'd4 : w_dlen;
               r_addr      <= w_grant_if ? bus.inst_addr : bus.data_addr;
               r_wdata     <= bus.data_i;
               r_word      <= '0;
               r_cnt       <= '0;
               bus.mem_a   <= w_grant_if ? bus.inst_addr : bus.data_addr;
               bus.mem_wr  <= w_grant_data & bus.data_we;
               bus.busy    <= 1'b1;
               if (w_grant_data && bus.data_we) bus.mem_dout <= bus.data_i[7:0];
            end
            IF_RD, DATA_RD: begin
               r_word <= w_word;
               r_cnt  <= w_next;
               // An abort beats completion, even on the final byte.
               if (r_state == IF_RD && bus.inst_flush) begin
                  r_state  <= IDLE;
                  r_cnt    <= '0;
                  bus.busy <= 1'b0;
               end else if (w_last) begin
                  r_state  <= IDLE;
                  r_cnt    <= '0;
                  bus.busy <= 1'b0;
                  if (r_state == IF_RD) begin
                     bus.inst_o    <= w_word;
                     bus.inst_pc   <= r_addr;
                     bus.inst_done <= 1'b1;
                  end else begin
                     bus.data_o    <= w_word;
                     bus.data_done <= 1'b1;
                  end
               end else
                  bus.mem_a <= r_addr + ADDR_WIDTH'(w_next);
            end
            DATA_WR: if (w_last) begin
               r_state       <= IDLE;
               r_cnt         <= '0;
               bus.mem_wr    <= 1'b0;
               bus.data_done <= 1'b1;
               bus.busy      <= 1'b0;
            end else begin
               r_cnt        <= w_next;
               bus.mem_a    <= r_addr + ADDR_WIDTH'(w_next);
               bus.mem_dout <= r_wdata[{w_next[1:0], 3'b000} +: 8];
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed transactions checked against a byte-array memory model
// and the alternating-priority grant rule.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   last_data = 1'b0;
   logic [7:0]  ram [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];
   logic [32:0] trace [$];

   mem_arbiter_if b ();
   mem_arbiter dut (.clk(clk), .rst(rst), .bus(b));

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction
   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : init_byte(a);
   endfunction
   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction
   function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < n; k++) w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
      return w;
   endfunction
   function automatic int len_bytes(input logic [1:0] l);
      return l[1] ? 4 : l[0] ? 2 : 1;
   endfunction
   function automatic logic [31:0] rand_addr();
      return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 7))
                                         : 32'h100 + 32'($urandom_range(0, 31));
   endfunction

   // RAM environment: combinational-style read settled by the half cycle, write on the edge.
   always @(negedge clk) b.mem_din = ram_rd(b.mem_a);
   always @(posedge clk) if (b.mem_wr) ram[b.mem_a] = b.mem_dout;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (b.busy) trace.push_back({b.mem_wr, b.mem_a});
      if (b.mem_wr) chk("wr_idle", 64'(b.busy), 64'd1);
   end

   task automatic run_if(input logic [31:0] a, output int t);
      b.inst_addr = a;
      b.inst_req  = 1'b1;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!b.inst_done && t < 40);
      chk("if_done", 64'(b.inst_done), 64'd1);
      chk("inst_o", 64'(b.inst_o), 64'(ref_word(a, 4)));
      chk("inst_pc", 64'(b.inst_pc), 64'(a));
      b.inst_req = 1'b0;
   endtask

   task automatic run_data(input logic [31:0] a, input logic we, input logic [1:0] len,
                           input logic [31:0] wd, input bit scramble, output int t);
      int n;
      n = len_bytes(len);
      b.data_addr = a;
      b.data_we   = we;
      b.data_len  = len;
      b.data_i    = wd;
      b.data_req  = 1'b1;
      t = 0;
      do begin
         @(posedge clk); #1; t++;
         if (scramble && t == 1) begin b.data_addr = ~a; b.data_i = ~wd; end
      end while (!b.data_done && t < 40);
      chk("data_done", 64'(b.data_done), 64'd1);
      if (we) for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8 * k +: 8];
      else chk("data_o", 64'(b.data_o), 64'(ref_word(a, n)));
      b.data_req = 1'b0;
   endtask

   task automatic single(input bit is_if, input logic [31:0] a, input logic we,
                         input logic [1:0] len, input logic [31:0] wd);
      int t, n;
      n = is_if ? 4 : len_bytes(len);
      trace.delete();
      if (is_if) run_if(a, t); else run_data(a, we, len, wd, 1'b1, t);
      chk("latency", 64'(t), 64'(n + 1));
      chk("trace_len", 64'(trace.size()), 64'(n));
      for (int k = 0; k < n && k < trace.size(); k++)
         chk("trace", 64'(trace[k]), 64'({is_if ? 1'b0 : we, a + 32'(k)}));
      last_data = !is_if;
      @(posedge clk); #1;
   endtask

   task automatic pair(input logic [31:0] ia, input logic [31:0] da, input logic we,
                       input logic [1:0] len, input logic [31:0] wd);
      int ti, td, nd;
      bit data_first;
      data_first = !last_data;
      nd = len_bytes(len);
      fork
         run_if(ia, ti);
         run_data(da, we, len, wd, 1'b0, td);
      join
      chk("pair_order", 64'(td < ti), 64'(data_first));
      if (data_first) begin
         chk("pair_lat_d", 64'(td), 64'(nd + 1));
         chk("pair_lat_i", 64'(ti), 64'(nd + 7));
      end else begin
         chk("pair_lat_i", 64'(ti), 64'd5);
         chk("pair_lat_d", 64'(td), 64'(nd + 7));
      end
      last_data = !data_first;
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int  t;
      bit  seen;
      b.inst_req = 1'b0; b.inst_addr = '0; b.inst_flush = 1'b0;
      b.data_req = 1'b0; b.data_we = 1'b0; b.data_len = 2'b00; b.data_addr = '0; b.data_i = '0;
      b.mem_din = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_inst_o", 64'(b.inst_o), 64'd0);
      chk("rst_inst_pc", 64'(b.inst_pc), 64'd0);
      chk("rst_inst_done", 64'(b.inst_done), 64'd0);
      chk("rst_data_o", 64'(b.data_o), 64'd0);
      chk("rst_data_done", 64'(b.data_done), 64'd0);
      chk("rst_mem_a", 64'(b.mem_a), 64'd0);
      chk("rst_mem_dout", 64'(b.mem_dout), 64'd0);
      chk("rst_mem_wr", 64'(b.mem_wr), 64'd0);
      chk("rst_busy", 64'(b.busy), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      // Contention straight out of reset: data, then IF, then data again.
      pair(32'h180, 32'h104, 1'b0, 2'b10, 32'h0);
      pair(32'h184, 32'h108, 1'b1, 2'b01, 32'h1234_5678);
      // IF-only fetch of a known instruction.
      ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
      ref_mem[32'h1000] = 8'h13; ref_mem[32'h1001] = 8'h05; ref_mem[32'h1002] = 8'h00; ref_mem[32'h1003] = 8'h00;
      single(1'b1, 32'h1000, 1'b0, 2'b10, 32'h0);
      chk("if_const", 64'(b.inst_o), 64'h513);
      // Store half, then read one of its bytes back.
      single(1'b0, 32'h20, 1'b1, 2'b01, 32'hDEAD_BEEF);
      single(1'b0, 32'h21, 1'b0, 2'b00, 32'h0);
      chk("ld_byte", 64'(b.data_o), 64'hBE);
      // Address wrap.
      single(1'b0, 32'hFFFF_FFFE, 1'b0, 2'b10, 32'h0);
      chk("wrap_a2", 64'(trace[2][31:0]), 64'd0);
      // Flush mid-fetch with a load waiting behind it.
      b.inst_addr = 32'h200; b.inst_req = 1'b1;
      @(posedge clk); #1;
      b.data_addr = 32'h120; b.data_we = 1'b0; b.data_len = 2'b10; b.data_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b.inst_flush = 1'b1; b.inst_req = 1'b0;
      @(posedge clk); #1;
      b.inst_flush = 1'b0;
      chk("flush_busy", 64'(b.busy), 64'd0);
      chk("flush_nodone", 64'(b.inst_done), 64'd0);
      @(posedge clk); #1;
      chk("flush_nodone2", 64'(b.inst_done), 64'd0);
      chk("flush_acc", 64'(b.busy), 64'd1);
      chk("flush_a", 64'(b.mem_a), 64'h120);
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!b.data_done && t < 40);
      chk("flush_lat", 64'(t), 64'd4);
      chk("flush_data", 64'(b.data_o), 64'(ref_word(32'h120, 4)));
      b.data_req = 1'b0; last_data = 1'b1;
      @(posedge clk); #1;
      // Flush landing on the final byte edge of a fetch.
      b.inst_addr = 32'h300; b.inst_req = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      b.inst_flush = 1'b1; b.inst_req = 1'b0;
      @(posedge clk); #1;
      b.inst_flush = 1'b0;
      chk("flush_last_done", 64'(b.inst_done), 64'd0);
      chk("flush_last_busy", 64'(b.busy), 64'd0);
      last_data = 1'b0;
      @(posedge clk); #1;
      // Randomized mix of lone and contending requests.
      for (int i = 0; i < 120; i++) begin
         logic [31:0] ia, da, wd;
         logic [1:0]  len;
         logic        we;
         int          mode;
         mode = $urandom_range(0, 2);
         ia   = rand_addr();
         da   = rand_addr();
         wd   = $urandom;
         len  = 2'($urandom_range(0, 3));
         we   = 1'($urandom_range(0, 1));
         if (mode == 0) single(1'b1, ia, 1'b0, 2'b10, 32'h0);
         else if (mode == 1) single(1'b0, da, we, len, wd);
         else pair(ia, da, we, len, wd);
      end
      // Asynchronous reset in the middle of a word store.
      b.data_addr = 32'h40; b.data_we = 1'b1; b.data_len = 2'b10; b.data_i = 32'h1122_3344; b.data_req = 1'b1;
      @(posedge clk); #1;
      chk("ar_wr", 64'(b.mem_wr), 64'd1);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("ar_mem_wr", 64'(b.mem_wr), 64'd0);
      chk("ar_busy", 64'(b.busy), 64'd0);
      chk("ar_mem_a", 64'(b.mem_a), 64'd0);
      b.data_req = 1'b0;
      seen = 1'b0;
      repeat (4) begin @(posedge clk); #1; seen = seen | b.data_done; end
      chk("ar_nodone", 64'(seen), 64'd0);
      ref_mem[32'h40] = 8'h44;
      rst = 1'b1; last_data = 1'b0;
      @(posedge clk); #1;
      single(1'b0, 32'h40, 1'b0, 2'b10, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide unified RAM port and shares it between instruction fetch (IF icache-miss refill) and the MEM stage (loads/stores).
- Converts each 1/2/4-byte request into a multi-cycle byte stream, assembles little-endian words, and returns them with a one-cycle done pulse.
- Arbitrates IF and MEM with alternating priority; an in-flight fetch aborts on branch flush.

Parameters:
ADDR_WIDTH, 32, width of request addresses and the RAM address bus

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
inst_req  in  1  IF fetch request; level, held until inst_done
inst_addr  in  ADDR_WIDTH  fetch byte address; stable while inst_req=1
inst_flush  in  1  branch flush; aborts an in-flight fetch
inst_o  out  32  fetched instruction word
inst_pc  out  ADDR_WIDTH  address that inst_o belongs to
inst_done  out  1  one-cycle pulse: inst_o/inst_pc valid
data_req  in  1  MEM access request; level, held until data_done
data_we  in  1  1=store, 0=load
data_len  in  2  00=byte, 01=half, 10/11=word
data_addr  in  ADDR_WIDTH  access byte address
data_i  in  32  store data; low bytes used
data_o  out  32  load data, zero-extended
data_done  out  1  one-cycle pulse: load data valid / store committed
mem_din  in  8  RAM read byte; valid the cycle after its address is driven
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_WIDTH  RAM byte address
mem_wr  out  1  1=write mem_dout to mem_a at the next edge
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, last_grant=IF. All outputs are 0: inst_o, inst_pc, inst_done, data_o, data_done, mem_a, mem_dout, mem_wr, busy.
- States: IDLE, IF_RD, DATA_RD, DATA_WR. All outputs are registered.
- Accept rule: accept only in IDLE with inst_done=0 and data_done=0. Requesters therefore get a one-cycle gap between back-to-back transactions.
- Arbitration:
  - Only one requester → it wins.
  - Both requesting → data wins unless last_grant=DATA, then IF wins.
  - last_grant updates on every accept.
  - Grants are non-preemptive.
  - inst_flush=1 at the accept edge blocks IF acceptance.
- Length n: 1, 2, or 4 bytes. IF is always n=4.
- Byte addresses: addr+k, k=0..n-1, modulo 2^ADDR_WIDTH (wraps).
- Read sequence (IF_RD, DATA_RD):
  - Accept edge E0: mem_a=addr, mem_wr=0, cnt=0.
  - Edge Ek (k=1..n): mem_din goes to byte lane k-1; if k<n, mem_a=addr+k.
  - At En: state=IDLE; assert the done pulse with the assembled word.
  - Unused upper bytes are 0.
  - IF: inst_pc=inst_addr.
- Write sequence (DATA_WR):
  - E0: mem_a=addr, mem_dout=data_i[7:0], mem_wr=1.
  - Ek (k=1..n-1): mem_a=addr+k, mem_dout=byte k.
  - En: mem_wr=0, data_done=1, state=IDLE.
- Latency: done goes high n edges after the accept edge (word: 4 edges after accept).
- Done pulses last exactly one cycle. data_o and inst_o/inst_pc hold their values until the next done of the same kind.
- Flush: inst_flush=1 sampled at any edge while in IF_RD → state=IDLE, cnt=0, no inst_done, mem_a unchanged. Flush has no effect in DATA_RD/DATA_WR or IDLE.
- Flush on the same edge as E4 of IF_RD: the abort wins and inst_done stays 0.
- Requests in flight are not re-sampled; inst_addr/data_* changes mid-transaction are ignored, since addresses are latched at accept.
- Reset asserted mid-transaction returns everything to reset values immediately. A partial store may leave some bytes written.
- mem_wr is never high outside DATA_WR.

Test Plan:
- IF-only: inst_addr=0x0000_1000, RAM bytes 13,05,00,00 → mem_a 0x1000..0x1003 on successive cycles; inst_done at edge 4 with inst_o=0x0000_0513, inst_pc=0x1000.
- Store half: data_addr=0x20, data_i=0xDEAD_BEEF, len=01 → writes 0xEF@0x20 then 0xBE@0x21 with mem_wr=1 for exactly 2 cycles; data_done at edge 2; load byte at 0x21 returns data_o=0x0000_00BE.
- Contention: inst_req and data_req both high from reset → data served first; IF granted next after a 1-cycle gap; on the third contention data is granted again.
- Flush: inst_flush pulsed after edge 2 of a fetch → no inst_done, busy=0 next cycle, and a pending data_req is accepted on the following edge.
- Wrap: load word at 0xFFFF_FFFE → mem_a sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Async reset: rst low mid-DATA_WR (between edges) → mem_wr, busy, and mem_a go to 0 without a clock edge; no data_done.
